// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Shares one single-port sprite ROM (1-cycle registered read) between the
// video renderer (vid) and game logic (obj). Video has fixed priority. A
// starvation guard forces an obj grant after STARVE_LIMIT consecutive denied
// cycles. Each granted (row, col) becomes a linear ROM address, and the
// tagged pixel comes back exactly two cycles after the grant.

module sprite_rom_arbiter #(
    parameter int         WIDTH        = 31,
    parameter int         HEIGHT       = 30,
    parameter logic [7:0] TRANSPARENT  = 8'h00,
    parameter int         STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       vid_req,
    input  logic [4:0] vid_row,
    input  logic [4:0] vid_col,
    output logic       vid_gnt,
    output logic       vid_rsp_valid,
    output logic [7:0] vid_rsp_data,

    input  logic       obj_req,
    input  logic [4:0] obj_row,
    input  logic [4:0] obj_col,
    output logic       obj_gnt,
    output logic       obj_rsp_valid,
    output logic [7:0] obj_rsp_data,

    output logic [9:0] rom_addr,
    input  logic [7:0] rom_data
);

    // The counter must be able to hold STARVE_LIMIT itself and is at least 3 bits wide.
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [9:0]       WIDTH_10 = 10'(WIDTH);
    localparam logic [5:0]       WIDTH_6  = 6'(WIDTH);
    localparam logic [5:0]       HEIGHT_6 = 6'(HEIGHT);

    // NORMAL: video wins ties. FORCE_OBJ: a waiting obj request wins.
    typedef enum logic {
        ARB_NORMAL    = 1'b0,
        ARB_FORCE_OBJ = 1'b1
    } arb_state_t;

    // Identifies which requester a pipeline entry belongs to.
    typedef enum logic {
        TAG_VID = 1'b0,
        TAG_OBJ = 1'b1
    } tag_t;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_next;

    logic             any_gnt;
    tag_t             sel_tag;
    logic [4:0]       sel_row;
    logic [4:0]       sel_col;
    logic [9:0]       addr_next;
    logic             oor_next;

    logic             s1_valid;
    tag_t             s1_tag;
    logic             s1_oor;
    logic             s2_valid;
    tag_t             s2_tag;
    logic             s2_oor;
    logic [7:0]       rsp_pixel;

    // Grant selection: forced obj first, then video, then obj when video is idle.
    always_comb begin
        vid_gnt = 1'b0;
        obj_gnt = 1'b0;
        if ((state == ARB_FORCE_OBJ) && obj_req) begin
            obj_gnt = 1'b1;
        end else if (vid_req) begin
            vid_gnt = 1'b1;
        end else if (obj_req) begin
            obj_gnt = 1'b1;
        end
    end

    // Starvation guard: count denied obj cycles and enter FORCE_OBJ when the
    // count reaches the limit, so the very next cycle belongs to obj.
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        if (obj_gnt) begin
            starve_cnt_next = '0;
            state_next      = ARB_NORMAL;
        end else if ((state == ARB_FORCE_OBJ) && !obj_req) begin
            starve_cnt_next = '0;
            state_next      = ARB_NORMAL;
        end else if (obj_req) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt_next = starve_cnt + 1'b1;
            end
            if (starve_cnt >= (CNT_MAX - 1'b1)) begin
                state_next = ARB_FORCE_OBJ;
            end
        end
    end

    // Arbitration state and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Pick the winning coordinates and form the linear address and range flag.
    always_comb begin
        any_gnt   = vid_gnt | obj_gnt;
        sel_tag   = obj_gnt ? TAG_OBJ : TAG_VID;
        sel_row   = obj_gnt ? obj_row : vid_row;
        sel_col   = obj_gnt ? obj_col : vid_col;
        addr_next = ({5'b00000, sel_row} * WIDTH_10) + {5'b00000, sel_col};
        oor_next  = ({1'b0, sel_row} >= HEIGHT_6) || ({1'b0, sel_col} >= WIDTH_6);
    end

    // Address stage: launch the ROM read and record tag and range flag.
    // rom_addr holds its last value when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= 10'd0;
            s1_valid <= 1'b0;
            s1_tag   <= TAG_VID;
            s1_oor   <= 1'b0;
        end else begin
            s1_valid <= any_gnt;
            if (any_gnt) begin
                rom_addr <= addr_next;
                s1_tag   <= sel_tag;
                s1_oor   <= oor_next;
            end
        end
    end

    // ROM stage: the sideband follows the ROM's own read register in lock-step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_tag   <= TAG_VID;
            s2_oor   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_oor   <= s1_oor;
        end
    end

    // Response steering: out-of-range pixels read as TRANSPARENT and data is
    // zeroed whenever its valid is low.
    always_comb begin
        rsp_pixel     = s2_oor ? TRANSPARENT : rom_data;
        vid_rsp_valid = s2_valid && (s2_tag == TAG_VID);
        obj_rsp_valid = s2_valid && (s2_tag == TAG_OBJ);
        vid_rsp_data  = vid_rsp_valid ? rsp_pixel : 8'h00;
        obj_rsp_data  = obj_rsp_valid ? rsp_pixel : 8'h00;
    end

endmodule
